instr_issue_queue: RTL and testbench

Upstream issue stage for the compute unit. It captures 16-bit instructions presented on the two 8-bit pin buses and discards illegal opcodes. Legal instructions are buffered in a small FIFO and issued one per cycle over a valid/ready handshake. The issued word is pre-split into the opcode/register/immediate fields the compute unit consumes, which decouples pin timing from execution.

---
 rtl/instr_issue_queue.sv | 125 ++++++++++++
 tb/tb_instr_issue_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: filters illegal opcodes, buffers legal words, issues pre-split fields.
// Latency 1 cycle (no empty bypass); in_ready low when full even with a same-cycle pop; ena low freezes.
module iq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_dat,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap modulo DEPTH; count alone distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
endmodule

// Top level: accept/pop qualification, opcode filter and saturating drop counter.
module instr_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          flush,
  input  logic [7:0]    in_hi,
  input  logic [7:0]    in_lo,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [15:0]   out_instr,
  output logic [3:0]    out_opcode,
  output logic [3:0]    out_tgt,
  output logic [3:0]    out_src0,
  output logic [3:0]    out_src1,
  output logic [7:0]    out_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic [7:0]    illegal_cnt
);
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] tgt;
    logic [3:0] src0;
    logic [3:0] src1;
  } instr_t;

  instr_t head;
  logic   full;
  logic   empty;
  logic   legal;
  logic   accept;
  logic   push;
  logic   pop;

  // Opcodes 0001..1000 are reserved and never reach the compute unit.
  assign legal  = (in_hi[7:4] == 4'h0) || (in_hi[7:4] >= 4'h9);
  assign in_ready  = ena && !rst && !full;
  assign out_valid = ena && !empty;
  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  iq_fifo #(.DEPTH(DEPTH), .W(16), .CW(CW)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push),
    .pop    (pop),
    .wr_dat ({in_hi, in_lo}),
    .rd_dat (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (accept && !legal && illegal_cnt != 8'hFF)
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign out_instr  = head;
  assign out_opcode = head.opcode;
  assign out_tgt    = head.tgt;
  assign out_src0   = head.src0;
  assign out_src1   = head.src1;
  assign out_imm    = {head.src0, head.src1};
endmodule

// File: tb/tb_instr_issue_queue.sv
module tb_instr_issue_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          flush;
  logic [7:0]    in_hi;
  logic [7:0]    in_lo;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_instr;
  logic [3:0]    out_opcode;
  logic [3:0]    out_tgt;
  logic [3:0]    out_src0;
  logic [3:0]    out_src1;
  logic [7:0]    out_imm;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [7:0]    illegal_cnt;

  instr_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_hi(in_hi), .in_lo(in_lo), .in_valid(in_valid), .in_ready(in_ready),
    .out_instr(out_instr), .out_opcode(out_opcode), .out_tgt(out_tgt),
    .out_src0(out_src0), .out_src1(out_src1), .out_imm(out_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of stored words plus the saturating drop counter.
  logic [15:0] m_q[$];
  int          m_ill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_legal(input logic [15:0] w);
    return (w[15:12] == 4'd0) || (w[15:12] >= 4'd9);
  endfunction

  task automatic check_outputs();
    logic exp_rdy;
    logic exp_vld;
    logic [15:0] h;
    exp_rdy = ena && (m_q.size() < DEPTH);
    exp_vld = ena && (m_q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
    if (exp_vld) begin
      h = m_q[0];
      chk("out_instr", 32'(out_instr), 32'(h));
      chk("out_opcode", 32'(out_opcode), 32'(h >> 12));
      chk("out_tgt", 32'(out_tgt), 32'((h >> 8) & 16'hF));
      chk("out_src0", 32'(out_src0), 32'((h >> 4) & 16'hF));
      chk("out_src1", 32'(out_src1), 32'(h & 16'hF));
      chk("out_imm", 32'(out_imm), 32'(h & 16'hFF));
    end
  endtask

  // One clock: drive at negedge, compare, then advance the model across the posedge.
  task automatic cycle(input logic e, input logic f, input logic v,
                       input logic [15:0] w, input logic r);
    bit acc;
    bit pop;
    @(negedge clk);
    ena = e; flush = f; in_valid = v; in_hi = w[15:8]; in_lo = w[7:0]; out_ready = r;
    #1;
    check_outputs();
    @(posedge clk);
    acc = e && v && (m_q.size() < DEPTH);
    pop = e && r && (m_q.size() != 0);
    if (acc && !is_legal(w) && m_ill < 255) m_ill++;
    if (f) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (acc && is_legal(w)) m_q.push_back(w);
    end
  endtask

  task automatic idle();
    ena = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  logic [15:0] fill_words[4] = '{16'hA012, 16'hB034, 16'hC056, 16'hD078};
  logic [15:0] ill_words[3]  = '{16'h1234, 16'h8FFF, 16'h0000};

  initial begin
    logic [15:0] w;
    rst = 1'b1; in_hi = '0; in_lo = '0;
    idle();
    #12;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst count", 32'(count), 0);
    chk("rst illegal_cnt", 32'(illegal_cnt), 0);
    chk("rst out_instr", 32'(out_instr), 0);
    @(negedge clk); rst = 1'b0;

    // First push after reset, visible one cycle later.
    cycle(1, 0, 1, 16'h9305, 0);
    #1;
    chk("load out_valid", 32'(out_valid), 1);
    chk("load out_opcode", 32'(out_opcode), 9);
    chk("load out_tgt", 32'(out_tgt), 3);
    chk("load out_imm", 32'(out_imm), 32'h05);
    chk("load count", 32'(count), 1);
    cycle(1, 0, 0, 16'h0, 1);

    // Fill to full, then a 5th word with a same-cycle pop must be refused.
    foreach (fill_words[i]) cycle(1, 0, 1, fill_words[i], 0);
    #1;
    chk("full count", 32'(count), 4);
    chk("full in_ready", 32'(in_ready), 0);
    cycle(1, 0, 1, 16'hE555, 1);
    #1;
    chk("full pop count", 32'(count), 3);
    chk("full pop head", 32'(out_instr), 32'hB034);
    repeat (3) cycle(1, 0, 0, 16'h0, 1);

    // Streaming ten words with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      w = {4'(9 + $urandom_range(0, 6)), 12'($urandom)};
      cycle(1, 0, 1, w, 1);
      #1;
      chk("stream count", 32'(count), 1);
    end
    cycle(1, 0, 0, 16'h0, 1);

    // Illegal filtering and counter saturation.
    foreach (ill_words[i]) cycle(1, 0, 1, ill_words[i], 0);
    #1;
    chk("ill count", 32'(illegal_cnt), 2);
    chk("ill queue count", 32'(count), 1);
    chk("ill head", 32'(out_instr), 32'h0000);
    for (int i = 0; i < 300; i++)
      cycle(1, 0, 1, {4'($urandom_range(1, 8)), 12'($urandom)}, 0);
    #1;
    chk("ill saturate", 32'(illegal_cnt), 255);
    cycle(1, 0, 0, 16'h0, 1);

    // Flush beats a same-cycle push.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 16'hF000 + 16'(i), 0);
    cycle(1, 1, 1, 16'hE100, 0);
    #1;
    chk("flush count", 32'(count), 0);
    chk("flush out_valid", 32'(out_valid), 0);
    cycle(1, 0, 0, 16'h0, 1);
    #1;
    chk("flush lost push", 32'(count), 0);

    // Stage disabled: everything frozen.
    cycle(1, 0, 1, 16'h9A01, 0);
    cycle(1, 0, 1, 16'h9B02, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 16'h9999, 1);
      #1;
      chk("ena count", 32'(count), 2);
      chk("ena in_ready", 32'(in_ready), 0);
      chk("ena out_valid", 32'(out_valid), 0);
    end

    // Asynchronous reset mid-cycle with a non-empty queue.
    cycle(1, 0, 0, 16'h0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst count", 32'(count), 0);
    chk("arst illegal_cnt", 32'(illegal_cnt), 0);
    chk("arst out_instr", 32'(out_instr), 0);
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst in_ready", 32'(in_ready), 0);
    idle();
    m_q.delete();
    m_ill = 0;
    @(negedge clk); rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
